// File: rtl/L1_cache_pkg.sv
// L1_cache_pkg: shared types and constants for the L1 instruction cache.
//   - core/icache fetch request type
//   - refill request/response structs exchanged with the AXI burst grabber
//   - refill controller FSM state enum
//   - line geometry constants and the line-offset width helper
package L1_cache_pkg;

    localparam int L1_ADDR_W         = 32;
    localparam int ICACHE_LINE_WORDS = 8;

    // Byte-offset bits inside a line of line_words 32-bit words.
    function automatic int line_off_w(input int line_words);
        return $clog2(4 * line_words);
    endfunction

    localparam int ICACHE_LINE_OFF_W = line_off_w(ICACHE_LINE_WORDS);

    // Core -> icache fetch request.
    typedef struct packed {
        logic                 valid;
        logic [L1_ADDR_W-1:0] addr;
    } icache_req_t;

    // Refill controller -> burst grabber line request.
    typedef struct packed {
        logic                 valid;
        logic [L1_ADDR_W-1:0] addr;
    } refill_req_t;

    // Burst grabber -> refill controller read beat.
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic        last;
    } refill_rsp_t;

    typedef enum logic [2:0] {
        RF_IDLE  = 3'd0,
        RF_REQ   = 3'd1,
        RF_FILL  = 3'd2,
        RF_DRAIN = 3'd3,
        RF_WRITE = 3'd4
    } refill_state_e;

endpackage

// File: rtl/icache_line_buffer.sv
// icache_line_buffer: assembles one cache line from 32-bit read beats.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (clears every word)
//   we_i        - write wdata_i into word[idx_i]
//   idx_i       - word index of the write
//   wdata_i     - beat data
//   clear_i     - qualified by we_i: every other word is zeroed by the same write
//   line_o      - assembled line, word 0 in the LSBs; holds until the next write
module icache_line_buffer #(
    parameter int LINE_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we_i,
    input  logic [$clog2(LINE_WORDS)-1:0] idx_i,
    input  logic [31:0]                  wdata_i,
    input  logic                         clear_i,
    output logic [32*LINE_WORDS-1:0]     line_o
);

    localparam int IDX_W = $clog2(LINE_WORDS);

    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            logic [31:0] word_q;
            logic [31:0] word_d;

            always_comb begin
                word_d = word_q;
                if (we_i) begin
                    if (idx_i == IDX_W'(gi)) begin
                        word_d = wdata_i;
                    end else if (clear_i) begin
                        word_d = '0;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign line_o[32*gi +: 32] = word_q;
        end
    endgenerate

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: turns an icache miss into one line-aligned burst read,
// assembles the returned beats and writes the line into the icache arrays.
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   miss_valid_i/miss_addr_i/miss_ready_o - miss handshake from the icache
//   flush_i                          - abandon the current refill
//   mem_req_valid_o/addr_o/ready_i   - burst request to the AXI grabber
//   mem_rvalid_i/rdata_i/rlast_i     - read beats (always accepted)
//   refill_valid_o/addr_o/line_o     - one-cycle line write into the icache
//   busy_o                           - controller not idle
//   err_o                            - one-cycle pulse on a burst-length mismatch
module icache_refill_ctrl
    import L1_cache_pkg::*;
#(
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     miss_valid_i,
    input  logic [ADDR_W-1:0]        miss_addr_i,
    output logic                     miss_ready_o,
    input  logic                     flush_i,
    output logic                     mem_req_valid_o,
    output logic [ADDR_W-1:0]        mem_req_addr_o,
    input  logic                     mem_req_ready_i,
    input  logic                     mem_rvalid_i,
    input  logic [31:0]              mem_rdata_i,
    input  logic                     mem_rlast_i,
    output logic                     refill_valid_o,
    output logic [ADDR_W-1:0]        refill_addr_o,
    output logic [32*LINE_WORDS-1:0] refill_line_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = line_off_w(LINE_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    refill_state_e    state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              flush_pend_q, flush_pend_d;
    logic              err_q, err_d;
    logic              buf_we;
    logic              buf_clear;
    refill_rsp_t       rsp;

    assign rsp = '{valid: mem_rvalid_i, data: mem_rdata_i, last: mem_rlast_i};

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        err_d        = 1'b0;
        buf_we       = 1'b0;
        buf_clear    = 1'b0;

        case (state_q)
            RF_IDLE: begin
                flush_pend_d = 1'b0;
                if (miss_valid_i && !flush_i) begin
                    addr_d             = miss_addr_i;
                    addr_d[OFF_W-1:0]  = '0;
                    state_d            = RF_REQ;
                end
            end

            RF_REQ: begin
                // A flush cannot withdraw the request; remember it so the
                // burst that follows is drained instead of stored.
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_req_ready_i) begin
                    cnt_d        = '0;
                    flush_pend_d = 1'b0;
                    state_d      = (flush_i || flush_pend_q) ? RF_DRAIN : RF_FILL;
                end
            end

            RF_FILL: begin
                if (flush_i) begin
                    // A beat in the flush cycle is swallowed; if it was the
                    // last one there is nothing left to drain.
                    state_d = (rsp.valid && rsp.last) ? RF_IDLE : RF_DRAIN;
                end else if (rsp.valid) begin
                    buf_we    = 1'b1;
                    // Word 0 starts a new line: wipe stale words of the previous one.
                    buf_clear = (cnt_q == '0);
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        if (rsp.last) begin
                            state_d = RF_WRITE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = RF_DRAIN;
                        end
                    end else if (rsp.last) begin
                        err_d   = 1'b1;
                        state_d = RF_IDLE;
                    end
                end
            end

            RF_DRAIN: begin
                if (rsp.valid && rsp.last) begin
                    state_d = RF_IDLE;
                end
            end

            RF_WRITE: begin
                state_d = RF_IDLE;
            end

            default: begin
                state_d = RF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RF_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            err_q        <= err_d;
        end
    end

    icache_line_buffer #(
        .LINE_WORDS(LINE_WORDS)
    ) u_line_buffer (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (buf_we),
        .idx_i  (cnt_q),
        .wdata_i(rsp.data),
        .clear_i(buf_clear),
        .line_o (refill_line_o)
    );

    // miss_ready_o is gated by rst_n so every output reads 0 while reset is held.
    assign miss_ready_o    = rst_n && (state_q == RF_IDLE);
    assign mem_req_valid_o = (state_q == RF_REQ);
    assign mem_req_addr_o  = addr_q;
    // A flush in the WRITE cycle must still kill the write, hence not registered.
    assign refill_valid_o  = (state_q == RF_WRITE) && !flush_i;
    assign refill_addr_o   = addr_q;
    assign busy_o          = (state_q != RF_IDLE);
    assign err_o           = err_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized scoreboard bench for icache_refill_ctrl.
module tb_icache_refill_ctrl;

    localparam int LW = 8;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              miss_valid = 1'b0;
    logic [AW-1:0]     miss_addr = '0;
    logic              miss_ready;
    logic              flush = 1'b0;
    logic              mem_req_valid;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_req_ready = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic              mem_rlast = 1'b0;
    logic              refill_valid;
    logic [AW-1:0]     refill_addr;
    logic [32*LW-1:0]  refill_line;
    logic              busy;
    logic              err;

    icache_refill_ctrl #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .miss_valid_i   (miss_valid),
        .miss_addr_i    (miss_addr),
        .miss_ready_o   (miss_ready),
        .flush_i        (flush),
        .mem_req_valid_o(mem_req_valid),
        .mem_req_addr_o (mem_req_addr),
        .mem_req_ready_i(mem_req_ready),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .mem_rlast_i    (mem_rlast),
        .refill_valid_o (refill_valid),
        .refill_addr_o  (refill_addr),
        .refill_line_o  (refill_line),
        .busy_o         (busy),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [32*LW-1:0] line;
    } refill_t;

    logic [AW-1:0] exp_req_q[$];
    refill_t       exp_ref_q[$];
    int            exp_err_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    bit lat_en = 1'b0;

    logic [AW-1:0] mon_addr;
    refill_t       mon_ref;
    int            mon_tok;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [32*LW-1:0] act, input logic [32*LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event seen but none expected", nm);
    endtask

    // Reference: the line base is the address rounded down to a whole line.
    function automatic logic [AW-1:0] line_base(input logic [AW-1:0] a);
        return a - (a % AW'(4 * LW));
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req_valid && mem_req_ready) begin
                if (exp_req_q.size() == 0) unexpected("mem_req");
                else begin
                    mon_addr = exp_req_q.pop_front();
                    check("req_addr", mem_req_addr, mon_addr);
                end
            end
            if (refill_valid) begin
                if (exp_ref_q.size() == 0) unexpected("refill");
                else begin
                    mon_ref = exp_ref_q.pop_front();
                    check("refill_addr", refill_addr, mon_ref.addr);
                    check("refill_line", refill_line, mon_ref.line);
                    if (lat_en) check("latency", cyc - accept_cyc + 1, LW + 2);
                end
            end
            if (err) begin
                if (exp_err_q.size() == 0) unexpected("err_pulse");
                else mon_tok = exp_err_q.pop_front();
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_miss(input logic [AW-1:0] a);
        int n = 0;
        miss_valid = 1'b1;
        miss_addr  = a;
        while (!miss_ready && n < 20) begin
            step();
            n++;
        end
        if (!miss_ready) unexpected("miss_ready_timeout");
        exp_req_q.push_back(line_base(a));
        step();
        accept_cyc = cyc;
        miss_valid = 1'b0;
        miss_addr  = $urandom;
    endtask

    // w back-pressure cycles; fat = cycle index of a flush (w = handshake cycle, -1 none)
    task automatic req_phase(input int w, input bit junk, input int fat, input logic [AW-1:0] ea);
        for (int i = 0; i < w; i++) begin
            mem_req_ready = 1'b0;
            flush = (i == fat);
            if (junk) begin
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
                mem_rlast  = 1'b0;
            end
            check("req_valid_hold", mem_req_valid, 1);
            check("req_addr_hold", mem_req_addr, ea);
            step();
        end
        mem_rvalid    = 1'b0;
        mem_req_ready = 1'b1;
        flush         = (fat == w);
        step();
        mem_req_ready = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input bit last, input int gmax, input bit fl);
        mem_rvalid = 1'b0;
        repeat ($urandom_range(0, gmax)) step();
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        mem_rlast  = last;
        flush      = fl;
        step();
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic t_normal(input logic [AW-1:0] a, input int w, input bit junk, input int gmax,
                            input bit fl_write, input bit fixed_data);
        logic [31:0]      d[LW];
        logic [32*LW-1:0] line;
        refill_t          r;
        for (int i = 0; i < LW; i++) begin
            d[i] = fixed_data ? 32'hA0 + 32'(i) : $urandom;
            line[32*i +: 32] = d[i];
        end
        issue_miss(a);
        if (!fl_write) begin
            r.addr = line_base(a);
            r.line = line;
            exp_ref_q.push_back(r);
        end
        lat_en = !fl_write && (w == 0) && (gmax == 0);
        req_phase(w, junk, -1, line_base(a));
        for (int i = 0; i < LW; i++) beat(d[i], i == LW - 1, gmax, 1'b0);
        if (fl_write) begin
            flush = 1'b1;
            #1;
            check("refill_suppressed", refill_valid, 0);
        end
        step();
        flush  = 1'b0;
        lat_en = 1'b0;
        check("idle_after_refill", busy, 0);
    endtask

    task automatic t_flush_fill(input logic [AW-1:0] a, input int w, input int k, input bit carry, input int gmax);
        int start;
        issue_miss(a);
        req_phase(w, 1'b0, -1, line_base(a));
        for (int i = 0; i < k; i++) beat($urandom, 1'b0, gmax, 1'b0);
        if (carry) begin
            beat($urandom, 1'b0, gmax, 1'b1);
            start = k + 1;
        end else begin
            flush = 1'b1;
            step();
            flush = 1'b0;
            start = k;
        end
        for (int i = start; i < LW; i++) begin
            check("drain_busy", busy, 1);
            beat($urandom, i == LW - 1, gmax, 1'b0);
        end
        check("idle_after_flush", busy, 0);
    endtask

    task automatic t_early(input logic [AW-1:0] a, input int w, input int e, input int gmax);
        exp_err_q.push_back(1);
        issue_miss(a);
        req_phase(w, 1'b0, -1, line_base(a));
        for (int i = 0; i < e; i++) beat($urandom, 1'b0, gmax, 1'b0);
        beat($urandom, 1'b1, gmax, 1'b0);
        check("idle_after_early", busy, 0);
    endtask

    task automatic t_nolast(input logic [AW-1:0] a, input int w, input int x, input int gmax);
        exp_err_q.push_back(1);
        issue_miss(a);
        req_phase(w, 1'b0, -1, line_base(a));
        for (int i = 0; i < LW; i++) beat($urandom, 1'b0, gmax, 1'b0);
        for (int j = 0; j < x; j++) begin
            check("drain_after_nolast", busy, 1);
            beat($urandom, 1'b0, gmax, 1'($urandom_range(0, 1)));
        end
        check("drain_before_rlast", busy, 1);
        beat($urandom, 1'b1, gmax, 1'($urandom_range(0, 1)));
        check("idle_after_drain", busy, 0);
    endtask

    task automatic t_flush_req(input logic [AW-1:0] a, input int w, input int gmax);
        issue_miss(a);
        req_phase(w, 1'b0, $urandom_range(0, w), line_base(a));
        for (int i = 0; i < LW; i++) beat($urandom, i == LW - 1, gmax, 1'b0);
        check("idle_after_req_flush", busy, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_refill_valid", refill_valid, 0);
        check("rst_err", err, 0);
        check("rst_line", refill_line, 0);
        check("rst_miss_ready", miss_ready, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_miss_ready", miss_ready, 1);
        step();

        // Directed cases
        t_normal(32'h0000_1234, 0, 1'b0, 0, 1'b0, 1'b1);
        t_normal($urandom, 5, 1'b1, 0, 1'b0, 1'b0);
        t_flush_fill($urandom, 0, 4, 1'b0, 0);
        t_early($urandom, 0, 5, 0);
        t_nolast($urandom, 0, 2, 0);

        // Flush in IDLE blocks the miss
        miss_valid = 1'b1;
        miss_addr  = $urandom;
        flush      = 1'b1;
        step();
        check("flush_blocks_miss", busy, 0);
        miss_valid = 1'b0;
        flush      = 1'b0;
        step();

        // Reset in the middle of a burst
        issue_miss($urandom);
        req_phase(0, 1'b0, -1, mem_req_addr);
        for (int i = 0; i < 3; i++) beat($urandom, 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_req_valid", mem_req_valid, 0);
        check("midrst_refill_valid", refill_valid, 0);
        check("midrst_err", err, 0);
        check("midrst_miss_ready", miss_ready, 0);
        check("midrst_line", refill_line, 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("release_miss_ready", miss_ready, 1);
        step();

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            int kind = $urandom_range(0, 5);
            int w    = $urandom_range(0, 5);
            int gmax = $urandom_range(0, 2);
            case (kind)
                0: t_normal($urandom, w, 1'($urandom_range(0, 1)), gmax, 1'b0, 1'b0);
                1: t_normal($urandom, w, 1'b0, gmax, 1'b1, 1'b0);
                2: t_flush_fill($urandom, w, $urandom_range(0, LW - 2), 1'($urandom_range(0, 1)), gmax);
                3: t_early($urandom, w, $urandom_range(0, LW - 2), gmax);
                4: t_nolast($urandom, w, $urandom_range(0, 3), gmax);
                default: t_flush_req($urandom, w, gmax);
            endcase
        end

        t_normal($urandom, 0, 1'b0, 0, 1'b0, 1'b0);
        repeat (3) step();
        check("req_q_drained", exp_req_q.size(), 0);
        check("refill_q_drained", exp_ref_q.size(), 0);
        check("err_q_drained", exp_err_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, 32-bit words per cache line (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have ports, one per line:
 clk  in  1  the only clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 miss_valid_i  in  1  icache reports a miss
 miss_addr_i  in  ADDR_W  missing fetch address
 miss_ready_o  out  1  miss accepted
 flush_i  in  1  pipeline flush, abandon the current refill
 mem_req_valid_o  out  1  burst read request to the AXI grabber
 mem_req_addr_o  out  ADDR_W  line-aligned burst address
 mem_req_ready_i  in  1  grabber accepts the request
 mem_rvalid_i  in  1  read beat valid (always accepted)
 mem_rdata_i  in  32  read beat data
 mem_rlast_i  in  1  final beat of the burst
 refill_valid_o  out  1  one-cycle line write into the icache arrays
 refill_addr_o  out  ADDR_W  line-aligned address of the written line
 refill_line_o  out  32*LINE_WORDS  assembled line, word 0 in the LSBs
 busy_o  out  1  controller is not IDLE
 err_o  out  1  one-cycle pulse on a burst-length mismatch

Function
REQ-004 SHALL implement the FSM states IDLE, REQ, FILL, DRAIN and WRITE.
REQ-005 In IDLE: miss_ready_o=1; on miss_valid_i and not flush_i, SHALL latch the address with its low log2(4*LINE_WORDS) bits cleared and go to REQ.
REQ-006 In REQ: mem_req_valid_o=1 and mem_req_addr_o holds the latched address, stable until mem_req_ready_i; on the handshake, SHALL clear the beat counter and go to FILL.
REQ-007 In FILL: each mem_rvalid_i SHALL write mem_rdata_i into word[counter] and increment the counter.
REQ-008 The counter SHALL be log2(LINE_WORDS) bits wide and wrap to 0 after LINE_WORDS-1.
REQ-009 When the counter is LINE_WORDS-1 and mem_rvalid_i=1 and mem_rlast_i=1, the FSM SHALL go to WRITE.
REQ-010 mem_rlast_i on a beat before LINE_WORDS-1 SHALL pulse err_o, discard the line and return to IDLE.
REQ-011 Beat LINE_WORDS-1 without mem_rlast_i SHALL pulse err_o and go to DRAIN.
REQ-012 In WRITE: refill_valid_o=1 for exactly one cycle with refill_addr_o and refill_line_o, then the FSM returns to IDLE; refill_line_o SHALL hold its value until the next FILL write.
REQ-013 Miss-to-refill latency with zero-wait memory SHALL be LINE_WORDS+2 cycles after the miss handshake.
REQ-014 flush_i in REQ SHALL not withdraw an asserted request; the request completes and the FSM goes to DRAIN.
REQ-015 flush_i in FILL SHALL go to DRAIN; a beat arriving in the flush cycle is consumed and not stored.
REQ-016 flush_i in WRITE SHALL suppress refill_valid_o and the FSM returns to IDLE.
REQ-017 flush_i in IDLE SHALL block acceptance of a miss in the same cycle.
REQ-018 DRAIN SHALL consume beats, write nothing, and return to IDLE on mem_rlast_i.
REQ-019 A flush during DRAIN SHALL have no effect.
REQ-020 busy_o SHALL be (state != IDLE).

Reset
REQ-021 rst_n low SHALL asynchronously force the FSM to IDLE.
REQ-022 Reset SHALL clear the counter, latched address, line buffer and refill_line_o to 0.
REQ-023 During reset mem_req_valid_o, refill_valid_o, err_o and busy_o SHALL be 0.
REQ-024 Reset SHALL take effect mid-burst; outstanding beats after reset release are the system's responsibility.

Structure
REQ-025 The FSM state enum and the refill request/response structs SHALL live in L1_cache_pkg, beside the core/icache request types.
REQ-026 The line-offset width constant SHALL live in L1_cache_pkg.
REQ-027 The line assembly buffer SHALL be one sub-module, icache_line_buffer (word write enable, index, clear).
REQ-028 All other logic SHALL be flat.

Verification
REQ-029 Zero-wait refill: miss 0x0000_1234 -> request addr 0x0000_1220; 8 beats 0xA0..0xA7 -> one refill_valid_o, line word0=0xA0, word7=0xA7, refill_addr_o=0x0000_1220, 10 cycles after accept.
REQ-030 Back-pressure: mem_req_ready_i low for 5 cycles -> mem_req_valid_o and address stable throughout; no beat is stored before the handshake.
REQ-031 Flush after beat 3 -> no refill_valid_o; DRAIN consumes beats 4..7; busy_o falls the cycle after rlast; the next miss is accepted.
REQ-032 Early rlast on beat 5 -> err_o pulses once; FSM IDLE; no refill.
REQ-033 Missing rlast on beat 7 -> err_o pulses once; FSM in DRAIN until rlast arrives.
REQ-034 rst_n asserted mid-FILL -> all outputs 0 immediately; after release, miss_ready_o=1 in the first cycle.
